// File: rtl/mm_burst_reader.sv
// Avalon-MM burst read master: streams the byte window [pkt_begin, pkt_end) into a FIFO.
// Optional macro BURST_4K_SPLIT_EN keeps every burst inside a single 4 KiB page.
module mm_burst_reader #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MAX_BURST    = 16,
    parameter int BURSTCOUNT_W = 16,
    parameter int FIFO_DEPTH   = 512,
    parameter int USEDW_W      = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             control,
    input  logic [ADDR_W-1:0]       pkt_begin,
    input  logic [ADDR_W-1:0]       pkt_end,
    input  logic [USEDW_W-1:0]      fifo_usedw,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    fifo_wr,
    output logic                    rdy,
    output logic [ADDR_W-1:0]       address,
    output logic                    read,
    output logic [BURSTCOUNT_W-1:0] burstcount,
    input  logic                    waitrequest,
    input  logic [DATA_W-1:0]       readdata,
    input  logic                    readdatavalid,
    output logic [ADDR_W-1:0]       words_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] MAX_LEN    = ADDR_W'(MAX_BURST);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    rdy_q, rdy_d;
    logic                    read_q, read_d;
    logic [ADDR_W-1:0]       address_q, address_d;
    logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
    logic [DATA_W-1:0]       fifo_data_q, fifo_data_d;
    logic                    fifo_wr_q, fifo_wr_d;
    logic [ADDR_W-1:0]       words_done_q, words_done_d;
    logic [ADDR_W-1:0]       begin_q, begin_d;
    logic [ADDR_W-1:0]       end_q, end_d;
    logic [31:0]             control_q, control_d;
    logic [ADDR_W-1:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0]       cur_addr_q, cur_addr_d;
    logic [BURSTCOUNT_W-1:0] beat_q, beat_d;

    logic [ADDR_W:0]   span;
    logic [ADDR_W-1:0] total;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] done_len;
    logic              credit_ok;
    int                free_words;
    logic              ctrl_unused;

    assign ctrl_unused = ^control_q;

    // Round the byte span up to whole words; only meaningful when end_q > begin_q.
    assign span     = {1'b0, end_q} - {1'b0, begin_q} + (ADDR_W + 1)'(BYTES - 1);
    assign total    = ADDR_W'(span >> SHIFT);
    assign done_len = ADDR_W'(burstcount_q);

`ifdef BURST_4K_SPLIT_EN
    logic [12:0]       page_bytes;
    logic [ADDR_W-1:0] page_words;
    assign page_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    assign page_words = ADDR_W'(page_bytes >> SHIFT);
`endif

    always_comb begin
        len = (remaining_q > MAX_LEN) ? MAX_LEN : remaining_q;
`ifdef BURST_4K_SPLIT_EN
        if (page_words < len) len = page_words;
`endif
    end

    // A write landing this cycle already consumes one slot the usedw count does not show yet.
    always_comb begin
        free_words = FIFO_DEPTH - int'(fifo_usedw) - int'(fifo_wr_q);
        credit_ok  = free_words >= int'(len);
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no path leaves a latch.
        state_d      = state_q;
        read_d       = read_q;
        address_d    = address_q;
        burstcount_d = burstcount_q;
        fifo_data_d  = fifo_data_q;
        fifo_wr_d    = 1'b0;
        words_done_d = words_done_q;
        begin_d      = begin_q;
        end_d        = end_q;
        control_d    = control_q;
        remaining_d  = remaining_q;
        cur_addr_d   = cur_addr_q;
        beat_d       = beat_q;

        case (state_q)
            S_IDLE: begin
                if (start && rdy_q) begin
                    begin_d      = pkt_begin & ALIGN_MASK;
                    end_d        = pkt_end;
                    control_d    = control;
                    words_done_d = '0;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                if (end_q > begin_q) begin
                    remaining_d = total;
                    cur_addr_d  = begin_q;
                    state_d     = S_ISSUE;
                end else begin
                    remaining_d = '0;
                    state_d     = S_DONE;
                end
            end
            S_ISSUE: begin
                if (!read_q) begin
                    if (credit_ok) begin
                        read_d       = 1'b1;
                        address_d    = cur_addr_q;
                        burstcount_d = BURSTCOUNT_W'(len);
                    end
                end else if (!waitrequest) begin
                    read_d  = 1'b0;
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (readdatavalid) begin
                    fifo_data_d  = readdata;
                    fifo_wr_d    = 1'b1;
                    words_done_d = words_done_q + 1'b1;
                    beat_d       = beat_q + 1'b1;
                    if (beat_d == burstcount_q) begin
                        remaining_d = remaining_q - done_len;
                        cur_addr_d  = cur_addr_q + (done_len << SHIFT);
                        state_d     = (remaining_d != '0) ? S_ISSUE : S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b0;
            read_q       <= 1'b0;
            address_q    <= '0;
            burstcount_q <= '0;
            fifo_data_q  <= '0;
            fifo_wr_q    <= 1'b0;
            words_done_q <= '0;
            begin_q      <= '0;
            end_q        <= '0;
            control_q    <= '0;
            remaining_q  <= '0;
            cur_addr_q   <= '0;
            beat_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            read_q       <= read_d;
            address_q    <= address_d;
            burstcount_q <= burstcount_d;
            fifo_data_q  <= fifo_data_d;
            fifo_wr_q    <= fifo_wr_d;
            words_done_q <= words_done_d;
            begin_q      <= begin_d;
            end_q        <= end_d;
            control_q    <= control_d;
            remaining_q  <= remaining_d;
            cur_addr_q   <= cur_addr_d;
            beat_q       <= beat_d;
        end
    end

    assign rdy        = rdy_q;
    assign read       = read_q;
    assign address    = address_q;
    assign burstcount = burstcount_q;
    assign fifo_data  = fifo_data_q;
    assign fifo_wr    = fifo_wr_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mm_burst_reader.sv
// Directed bench for mm_burst_reader: Avalon slave model plus command and data scoreboards.
// Expected bursts follow BURST_4K_SPLIT_EN when it is defined for the build.
module tb_mm_burst_reader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int BC_W    = 16;
    localparam int USEDW_W = 9;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BC_W-1:0]   len;
    } cmd_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        control = '0;
    logic [ADDR_W-1:0]  pkt_begin = '0;
    logic [ADDR_W-1:0]  pkt_end = '0;
    logic [USEDW_W-1:0] fifo_usedw = '0;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_wr;
    logic               rdy;
    logic [ADDR_W-1:0]  address;
    logic               read;
    logic [BC_W-1:0]    burstcount;
    logic               waitrequest = 1'b0;
    logic [DATA_W-1:0]  readdata = '0;
    logic               readdatavalid = 1'b0;
    logic [ADDR_W-1:0]  words_done;

    mm_burst_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .control       (control),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .fifo_usedw    (fifo_usedw),
        .fifo_data     (fifo_data),
        .fifo_wr       (fifo_wr),
        .rdy           (rdy),
        .address       (address),
        .read          (read),
        .burstcount    (burstcount),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .words_done    (words_done)
    );

    initial forever #5 clk = ~clk;

    int                checks = 0;
    int                failures = 0;
    logic [DATA_W-1:0] exp_data[$];
    cmd_t              exp_cmd[$];
    int                wr_count = 0;
    int                accepts = 0;
    int                hold_count = 0;
    int                wait_cfg = 0;
    bit                gap_mode = 1'b0;
    bit                slave_abort = 1'b0;
    logic [DATA_W-1:0] data_base = '0;
    int                lat;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Slave and FIFO monitor act on the falling edge; the directed steps act 2 ns later.
    task automatic slave_loop();
        int                stall_cnt = 0;
        int                beats_left = 0;
        int                beat_idx = 0;
        bit                gap_tick = 1'b0;
        bit                prev_read = 1'b0;
        bit                prev_wait = 1'b0;
        logic [ADDR_W-1:0] prev_addr = '0;
        logic [BC_W-1:0]   prev_bc = '0;
        cmd_t              c;
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                wr_count++;
                if (exp_data.size() == 0) check("spurious_fifo_wr", fifo_wr, 1'b0);
                else check("fifo_data", fifo_data, exp_data.pop_front());
            end
            if (prev_read && prev_wait) begin
                hold_count++;
                check("hold_read", read, 1'b1);
                check("hold_address", address, prev_addr);
                check("hold_burstcount", burstcount, prev_bc);
            end
            if (slave_abort) begin
                stall_cnt = 0;
                beats_left = 0;
                gap_tick = 1'b0;
                readdatavalid = 1'b0;
                waitrequest = 1'b0;
                prev_read = 1'b0;
                prev_wait = 1'b0;
                exp_data.delete();
                exp_cmd.delete();
            end else begin
                if (beats_left > 0 && !(gap_mode && gap_tick)) begin
                    readdata = data_base + DATA_W'(beat_idx);
                    readdatavalid = 1'b1;
                    exp_data.push_back(readdata);
                    beat_idx++;
                    beats_left--;
                end else begin
                    readdatavalid = 1'b0;
                end
                gap_tick = ~gap_tick;
                waitrequest = 1'b0;
                if (read === 1'b1) begin
                    if (stall_cnt < wait_cfg) begin
                        waitrequest = 1'b1;
                        stall_cnt++;
                    end else begin
                        stall_cnt = 0;
                        accepts++;
                        check("one_outstanding", beats_left, 0);
                        if (exp_cmd.size() == 0) begin
                            check("spurious_read", read, 1'b0);
                        end else begin
                            c = exp_cmd.pop_front();
                            check("cmd_address", address, c.addr);
                            check("cmd_burstcount", burstcount, c.len);
                        end
                        beats_left = int'(burstcount);
                        beat_idx = 0;
                    end
                end
                prev_read = (read === 1'b1);
                prev_wait = waitrequest;
                prev_addr = address;
                prev_bc   = burstcount;
            end
        end
    endtask

    task automatic start_transfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e);
        check("rdy_before_start", rdy, 1'b1);
        wr_count = 0;
        accepts = 0;
        hold_count = 0;
        pkt_begin = b;
        pkt_end = e;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        check("rdy_low_after_start", rdy, 1'b0);
    endtask

    // A second start is pulsed while busy; it must be ignored.
    task automatic finish_transfer(input int words, input int ncmd, output int latency);
        int cyc = 0;
        while (rdy !== 1'b1 && cyc < 2000) begin
            @(negedge clk); #2;
            cyc++;
            if (cyc == 1) begin
                start = 1'b1;
                pkt_begin = 32'h8000;
                pkt_end = 32'h9000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        latency = cyc;
        check("transfer_completes", rdy, 1'b1);
        check("fifo_write_count", wr_count, words);
        check("words_done", words_done, words);
        check("cmds_accepted", accepts, ncmd);
        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("data_queue_empty", exp_data.size(), 0);
    endtask

    initial begin
        fork
            slave_loop();
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check("rst_read", read, 1'b0);
        check("rst_fifo_wr", fifo_wr, 1'b0);
        check("rst_rdy", rdy, 1'b0);
        check("rst_address", address, 0);
        check("rst_burstcount", burstcount, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_words_done", words_done, 0);
        reset = 1'b1;
        @(negedge clk); #2;
        check("rdy_after_reset", rdy, 1'b1);

        // 1: 17 words over two bursts
        data_base = 32'd10;
        exp_cmd.push_back('{addr: 32'h0, len: 16'd16});
        exp_cmd.push_back('{addr: 32'h40, len: 16'd1});
        start_transfer(32'h0, 32'd66);
        finish_transfer(17, 2, lat);

        // 2: waitrequest held for three cycles, with readdatavalid gaps
        wait_cfg = 3;
        gap_mode = 1'b1;
        data_base = 32'h200;
        exp_cmd.push_back('{addr: 32'h200, len: 16'd8});
        start_transfer(32'h200, 32'h220);
        finish_transfer(8, 1, lat);
        check("wait_hold_cycles", hold_count, 3);
        wait_cfg = 0;
        gap_mode = 1'b0;

        // 3: credit stall, free=12 and free=15 hold read low, free=16 releases it
        fifo_usedw = 9'd500;
        data_base = 32'h300;
        exp_cmd.push_back('{addr: 32'h300, len: 16'd16});
        start_transfer(32'h300, 32'h340);
        repeat (4) begin
            @(negedge clk); #2;
            check("credit_stall_500", read, 1'b0);
        end
        fifo_usedw = 9'd497;
        repeat (4) begin
            @(negedge clk); #2;
            check("credit_stall_497", read, 1'b0);
        end
        fifo_usedw = 9'd496;
        @(negedge clk); #2;
        check("credit_release_496", read, 1'b1);
        finish_transfer(16, 1, lat);
        fifo_usedw = '0;

        // 4: zero-length and inverted windows
        start_transfer(32'h100, 32'h100);
        finish_transfer(0, 0, lat);
        check("zero_len_rdy_latency", lat, 2);
        start_transfer(32'h700, 32'h600);
        finish_transfer(0, 0, lat);
        check("inverted_rdy_latency", lat, 2);

        // Unaligned begin rounds down, partial last word rounds up
        data_base = 32'h500;
        exp_cmd.push_back('{addr: 32'h500, len: 16'd3});
        start_transfer(32'h503, 32'h509);
        finish_transfer(3, 1, lat);

        // 5: reset in the middle of a 16-beat burst
        data_base = 32'h400;
        exp_cmd.push_back('{addr: 32'h400, len: 16'd16});
        start_transfer(32'h400, 32'h440);
        for (int i = 0; i < 200 && wr_count < 5; i++) begin
            @(negedge clk); #2;
        end
        check("reached_beat5", wr_count >= 5, 1'b1);
        reset = 1'b0;
        slave_abort = 1'b1;
        @(negedge clk); #2;
        check("midrst_read", read, 1'b0);
        check("midrst_fifo_wr", fifo_wr, 1'b0);
        check("midrst_words_done", words_done, 0);
        check("midrst_rdy", rdy, 1'b0);
        reset = 1'b1;
        slave_abort = 1'b0;
        @(negedge clk); #2;
        check("rdy_after_midrst", rdy, 1'b1);

        // 6: window straddling a 4 KiB page, 20 words
        data_base = 32'h600;
        gap_mode = 1'b1;
`ifdef BURST_4K_SPLIT_EN
        exp_cmd.push_back('{addr: 32'hFF0, len: 16'd4});
        exp_cmd.push_back('{addr: 32'h1000, len: 16'd16});
`else
        exp_cmd.push_back('{addr: 32'hFF0, len: 16'd16});
        exp_cmd.push_back('{addr: 32'h1030, len: 16'd4});
`endif
        start_transfer(32'hFF0, 32'h1040);
        finish_transfer(20, 2, lat);
        gap_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
